// File: rtl/bp_me_irq_forwarder_pkg.sv
// Types shared by the interrupt forwarder: BedRock memory header subset and FSM states.
package bp_me_irq_forwarder_pkg;

  localparam int paddr_width_gp = 40;
  localparam int dword_width_gp = 64;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [15:0]               payload;
    bp_bedrock_msg_size_e      size;
    logic [paddr_width_gp-1:0] addr;
    logic [3:0]                subop;
    bp_bedrock_mem_type_e      msg_type;
  } bp_bedrock_mem_header_s;

  localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_send  = 2'd1,
    e_wait  = 2'd2
  } bp_me_irq_fwd_state_e;

  function automatic bp_bedrock_mem_header_s uc_wr_header(input logic [paddr_width_gp-1:0] addr);
    bp_bedrock_mem_header_s h;
    h          = '0;
    h.msg_type = e_bedrock_mem_uc_wr;
    h.addr     = addr;
    h.size     = e_bedrock_msg_size_8;
    return h;
  endfunction

endpackage

// File: rtl/bp_me_irq_forwarder_if.sv
// BedRock command/response channel pair between the forwarder (master) and the memory path.
interface bp_me_irq_forwarder_if;
  import bp_me_irq_forwarder_pkg::*;

  bp_bedrock_mem_header_s      mem_cmd_header_o;
  logic [dword_width_gp-1:0]   mem_cmd_data_o;
  logic                        mem_cmd_v_o;
  logic                        mem_cmd_ready_and_i;
  logic                        mem_cmd_last_o;
  bp_bedrock_mem_header_s      mem_resp_header_i;
  logic [dword_width_gp-1:0]   mem_resp_data_i;
  logic                        mem_resp_v_i;
  logic                        mem_resp_ready_and_o;
  logic                        mem_resp_last_i;

  modport master (
    output mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o, mem_resp_ready_and_o,
    input  mem_cmd_ready_and_i, mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i
  );

  modport slave (
    input  mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o, mem_resp_ready_and_o,
    output mem_cmd_ready_and_i, mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i
  );
endinterface

// File: rtl/bp_me_irq_forwarder_debounce.sv
// Synchronises the sources, ORs the enabled ones and reports when that level has settled.
module bp_me_irq_forwarder_debounce #(
  parameter int num_src_p  = 8,
  parameter int debounce_p = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_src_p-1:0] src_i,
  input  logic [num_src_p-1:0] src_mask_i,
  output logic                 candidate_o,
  output logic                 stable_o
);

  localparam int cnt_w_lp = (debounce_p > 0) ? $clog2(debounce_p + 1) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(debounce_p);

  logic [num_src_p-1:0] sync1_r, sync2_r;
  logic [cnt_w_lp-1:0]  cnt_r;
  logic                 candidate_r;
  logic                 agg;

  assign agg = |(sync2_r & src_mask_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_r     <= '0;
      sync2_r     <= '0;
      candidate_r <= 1'b0;
      cnt_r       <= '0;
    end else begin
      sync1_r <= src_i;
      sync2_r <= sync1_r;
      if (agg != candidate_r) begin
        candidate_r <= agg;
        cnt_r       <= '0;
      end else if (cnt_r < cnt_max_lp) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign candidate_o = candidate_r;
  assign stable_o    = (cnt_r == cnt_max_lp);

endmodule

// File: rtl/bp_me_irq_forwarder.sv
// Forwards the debounced interrupt level to a target CLINT PLIC register as a BedRock uc write.
//   state   | meaning
//   e_ready | idle, waiting for a settled level that differs from the last acked one
//   e_send  | uc write presented on mem_cmd, held until accepted
//   e_wait  | write accepted, waiting for the single-beat response
module bp_me_irq_forwarder
  import bp_me_irq_forwarder_pkg::*;
#(
  parameter int num_src_p  = 8,
  parameter int debounce_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [num_src_p-1:0]      src_i,
  input  logic [num_src_p-1:0]      src_mask_i,
  input  logic [paddr_width_gp-1:0] tgt_addr_i,
  bp_me_irq_forwarder_if.master     bus,
  output logic                      irq_level_o,
  output logic                      busy_o
);

  bp_me_irq_fwd_state_e state_r;
  logic candidate, stable;
  logic val_r, sent_r, cmd_v_r, resp_ready_r, busy_r;

  bp_me_irq_forwarder_debounce #(
    .num_src_p (num_src_p),
    .debounce_p(debounce_p)
  ) debounce (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .src_i      (src_i),
    .src_mask_i (src_mask_i),
    .candidate_o(candidate),
    .stable_o   (stable)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_ready;
      val_r        <= 1'b0;
      sent_r       <= 1'b0;
      cmd_v_r      <= 1'b0;
      resp_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        e_ready: if (stable && (candidate != sent_r)) begin
          val_r   <= candidate;
          cmd_v_r <= 1'b1;
          busy_r  <= 1'b1;
          state_r <= e_send;
        end
        e_send: if (cmd_v_r && bus.mem_cmd_ready_and_i) begin
          cmd_v_r      <= 1'b0;
          resp_ready_r <= 1'b1;
          state_r      <= e_wait;
        end
        e_wait: if (bus.mem_resp_v_i) begin
          sent_r       <= val_r;
          resp_ready_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= e_ready;
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  assign bus.mem_cmd_header_o     = uc_wr_header(tgt_addr_i);
  assign bus.mem_cmd_data_o       = {{(dword_width_gp-1){1'b0}}, val_r};
  assign bus.mem_cmd_v_o          = cmd_v_r;
  assign bus.mem_cmd_last_o       = 1'b1;
  assign bus.mem_resp_ready_and_o = resp_ready_r;
  assign irq_level_o              = sent_r;
  assign busy_o                   = busy_r;

  // Response contents carry nothing this block needs.
  logic unused_resp;
  assign unused_resp = ^{bus.mem_resp_header_i, bus.mem_resp_data_i};

  resp_single_beat: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == e_wait && bus.mem_resp_v_i) |-> bus.mem_resp_last_i);

endmodule
